// File: rtl/calc_controller_if.sv
// calc_controller_if: keypad strobes, ALU bus and display signals of the calculator controller
interface calc_controller_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       op_valid;
    logic [1:0] op_sel;
    logic       eq_valid;
    logic       clr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_status;
    logic [7:0] disp_value;
    logic       disp_err;
    logic       status_flag;
    logic       busy;
    logic       done;
    modport slave (
        input  digit_valid, digit, op_valid, op_sel, eq_valid, clr, alu_result, alu_status,
        output alu_a, alu_b, alu_op, disp_value, disp_err, status_flag, busy, done
    );
    modport master (
        output digit_valid, digit, op_valid, op_sel, eq_valid, clr, alu_result, alu_status,
        input  alu_a, alu_b, alu_op, disp_value, disp_err, status_flag, busy, done
    );
endinterface

// File: rtl/calc_controller.sv
// calc_controller: keypad-driven calculator FSM sequencing operands into an external ALU
module calc_controller #(
    parameter int ALU_WAIT = 1
) (
    input logic clk,
    input logic rst,
    calc_controller_if.slave bus
);
    typedef enum logic [2:0] {ENTER_A, GOT_OP, ENTER_B, EXEC, SHOW, ERR} state_t;
    state_t state;
    logic [3:0] a, b, cnt;
    logic [1:0] op;
    logic [7:0] result;
    logic flag, done;
    logic dig_ok;
    assign dig_ok = bus.digit_valid && bus.digit <= 4'd9;
    assign bus.alu_a = a;
    assign bus.alu_b = b;
    assign bus.alu_op = op;
    assign bus.status_flag = flag;
    assign bus.done = done;
    assign bus.busy = state == EXEC;
    assign bus.disp_err = state == ERR;
    assign bus.disp_value = state == ERR ? 8'hFF :
                            state == SHOW ? result :
                            (state == ENTER_B || state == EXEC) ? {4'h0, b} : {4'h0, a};
    // keypad sequencing, ALU wait countdown and result capture; clr wins over every other strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ENTER_A;
            a <= '0;
            b <= '0;
            op <= '0;
            result <= '0;
            cnt <= '0;
            flag <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.clr) begin
                state <= ENTER_A;
                a <= '0;
                b <= '0;
                op <= '0;
                result <= '0;
                cnt <= '0;
                flag <= 1'b0;
            end else begin
                case (state)
                    ENTER_A: if (!bus.eq_valid) begin
                        if (bus.op_valid) begin
                            op <= bus.op_sel;
                            state <= GOT_OP;
                        end else if (dig_ok) a <= bus.digit;
                    end
                    GOT_OP: if (!bus.eq_valid) begin
                        if (bus.op_valid) op <= bus.op_sel;
                        else if (dig_ok) begin
                            b <= bus.digit;
                            state <= ENTER_B;
                        end
                    end
                    ENTER_B: if (bus.eq_valid) begin
                        cnt <= 4'(ALU_WAIT);
                        state <= EXEC;
                    end else if (!bus.op_valid && dig_ok) b <= bus.digit;
                    EXEC: if (cnt == 4'd1) begin
                        result <= bus.alu_result;
                        flag <= bus.alu_status;
                        done <= 1'b1;
                        cnt <= '0;
                        state <= (op == 2'b11 && bus.alu_status) ? ERR : SHOW;
                    end else cnt <= cnt - 4'd1;
                    // a result only chains if it fits in 4 bits and is not a borrowed (negative) difference
                    SHOW: if (!bus.eq_valid) begin
                        if (bus.op_valid) begin
                            if (result[7:4] == 4'h0 && !(op == 2'b01 && flag)) begin
                                a <= result[3:0];
                                op <= bus.op_sel;
                                state <= GOT_OP;
                            end else state <= ERR;
                        end else if (dig_ok) begin
                            a <= bus.digit;
                            result <= '0;
                            state <= ENTER_A;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule
